// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster timing generator. Produces pixel column and line
//                counters with registered sync, blanking and frame-origin
//                strobes, all aligned to the counters shown in the same cycle.
//  Ports       : pclk        - pixel clock
//                rst         - asynchronous active-high reset
//                hcount_out  - current pixel column (11 bit)
//                vcount_out  - current line (11 bit)
//                hsync_out   - active-high horizontal sync
//                vsync_out   - active-high vertical sync (whole lines)
//                hblnk_out   - high outside the visible columns
//                vblnk_out   - high outside the visible lines
//                frame_start - one-cycle pulse when the raster wraps to (0,0)
//                frame_cnt   - completed-frame count (16 bit)
//  Options     : VGA_TIMING_FRAME_CNT_EN - when defined, frame_cnt counts
//                frames; when undefined, frame_cnt is tied to zero and no
//                counter register exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Thresholds pre-sized to the counter width so all compares are 11 bit.
  localparam logic [10:0] c_h_last     = 11'(c_h_total - 1);
  localparam logic [10:0] c_h_blank    = 11'(H_ACTIVE);
  localparam logic [10:0] c_hs_first   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_hs_last    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] c_v_last     = 11'(c_v_total - 1);
  localparam logic [10:0] c_v_blank    = 11'(V_ACTIVE);
  localparam logic [10:0] c_vs_first   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_vs_last    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] r_hcount;
  logic [10:0] r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_hblnk;
  logic        r_vblnk;
  logic        r_frame_start;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [10:0] w_hcount_next;
  logic [10:0] w_vcount_next;

  always_comb begin
    w_h_wrap      = (r_hcount == c_h_last);
    w_v_wrap      = (r_vcount == c_v_last);
    w_hcount_next = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
    w_vcount_next = r_vcount;
    if (w_h_wrap) begin
      w_vcount_next = w_v_wrap ? 11'd0 : r_vcount + 11'd1;
    end
  end

  // Every strobe is decoded from the *next* counter values and registered
  // on the same edge as the counters, so outputs carry zero relative skew.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_hcount      <= 11'd0;
      r_vcount      <= 11'd0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_hcount_next;
      r_vcount      <= w_vcount_next;
      r_hsync       <= (w_hcount_next >= c_hs_first) && (w_hcount_next <= c_hs_last);
      r_vsync       <= (w_vcount_next >= c_vs_first) && (w_vcount_next <= c_vs_last);
      r_hblnk       <= (w_hcount_next >= c_h_blank);
      r_vblnk       <= (w_vcount_next >= c_v_blank);
      // Only a genuine wrap from the last pixel marks a frame origin, so
      // the (0,0) seen right after reset does not pulse.
      r_frame_start <= w_h_wrap && w_v_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Advances on the wrap edge so the new count appears alongside the
  // frame_start pulse; rolls over naturally at 16 bits.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= 16'd0;
    end else if (w_h_wrap && w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

  assign hcount_out  = r_hcount;
  assign vcount_out  = r_vcount;
  assign hsync_out   = r_hsync;
  assign vsync_out   = r_vsync;
  assign hblnk_out   = r_hblnk;
  assign vblnk_out   = r_vblnk;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. A reduced raster
//                keeps whole-frame runs short. A reference raster model
//                pushes expected outputs into a queue on each clock edge;
//                they are popped and compared on the following falling edge.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int HA = 16;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int VA = 12;
  localparam int VF = 1;
  localparam int VS = 3;
  localparam int VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        pclk;
  logic        rst;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic        frame_start;
  logic [15:0] frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) u_dut (
    .pclk        (pclk),
    .rst         (rst),
    .hcount_out  (hcount_out),
    .vcount_out  (vcount_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .hblnk_out   (hblnk_out),
    .vblnk_out   (vblnk_out),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] h;
    logic [31:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference raster state: what the outputs should show after the edge.
  int m_h  = 0;
  int m_v  = 0;
  int m_fs = 0;
  int m_fc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_h  = 0;
    m_v  = 0;
    m_fs = 0;
    m_fc = 0;
  endtask

  task automatic model_advance();
    m_fs = (m_h == HT - 1 && m_v == VT - 1) ? 1 : 0;
    if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    if (m_fs != 0) m_fc = (m_fc + 1) % 65536;
`endif
  endtask

  // Expected outputs straight from the raster definitions; reset forces all
  // strobes low regardless of position.
  task automatic push_expected(input bit in_reset);
    exp_t e;
    e.h  = 32'(m_h);
    e.v  = 32'(m_v);
    e.hb = !in_reset && (m_h >= HA);
    e.vb = !in_reset && (m_v >= VA);
    e.hs = !in_reset && (m_h >= HA + HF) && (m_h <= HA + HF + HS - 1);
    e.vs = !in_reset && (m_v >= VA + VF) && (m_v <= VA + VF + VS - 1);
    e.fs = !in_reset && (m_fs != 0);
    e.fc = 32'(m_fc);
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("hcount",      32'(hcount_out),  e.h);
      chk("vcount",      32'(vcount_out),  e.v);
      chk("hsync",       32'(hsync_out),   32'(e.hs));
      chk("vsync",       32'(vsync_out),   32'(e.vs));
      chk("hblnk",       32'(hblnk_out),   32'(e.hb));
      chk("vblnk",       32'(vblnk_out),   32'(e.vb));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("frame_cnt",   32'(frame_cnt),   e.fc);
    end
  endtask

  // One clock: model follows the edge, DUT is sampled on the falling edge.
  task automatic tick();
    @(posedge pclk);
    if (rst) begin
      model_reset();
      push_expected(1'b1);
    end else begin
      model_advance();
      push_expected(1'b0);
    end
    @(negedge pclk);
    pop_compare();
  endtask

  int hs_line0;
  int hb_line0;
  int vs_frame0;
  int vb_frame0;
  int fs_count;
  int fs_last;
  int fs_gap_bad;
  int idx;
  int budget;

  initial begin
    rst = 1'b1;
    model_reset();

    // Reset held for five cycles: everything stays at zero.
    for (int i = 0; i < 5; i++) tick();

    // Release between edges; until the next edge the raster shows (0,0).
    rst = 1'b0;
    #1;
    push_expected(1'b0);
    pop_compare();

    hs_line0   = 0;
    hb_line0   = 0;
    vs_frame0  = 0;
    vb_frame0  = 0;
    fs_count   = 0;
    fs_last    = 0;
    fs_gap_bad = 0;
    // Index 0 is the (0,0) cycle just checked; its strobes are all low.

    for (idx = 1; idx <= 3 * FRAME; idx++) begin
      tick();
      if (idx < HT) begin
        if (hsync_out) hs_line0++;
        if (hblnk_out) hb_line0++;
      end
      if (idx < FRAME) begin
        if (vsync_out) vs_frame0++;
        if (vblnk_out) vb_frame0++;
      end
      if (frame_start) begin
        if (idx - fs_last != FRAME) fs_gap_bad++;
        fs_last = idx;
        fs_count++;
      end
    end

    chk("hsync_cycles_line0",  32'(hs_line0),   32'(HS));
    chk("hblnk_cycles_line0",  32'(hb_line0),   32'(HT - HA));
    chk("vsync_cycles_frame0", 32'(vs_frame0),  32'(VS * HT));
    chk("vblnk_cycles_frame0", 32'(vb_frame0),  32'((VT - VA) * HT));
    chk("frame_start_pulses",  32'(fs_count),   32'd3);
    chk("frame_start_spacing", 32'(fs_gap_bad), 32'd0);
    chk("frame_start_last_at", 32'(fs_last),    32'(3 * FRAME));

    // Walk to a mid-frame position, bounded by one frame of cycles.
    budget = 0;
    while (!(m_h == HA / 2 + 2 && m_v == VA / 2 + 1) && budget < FRAME) begin
      tick();
      budget++;
    end
    chk("reach_midframe", 32'(budget < FRAME), 32'd1);

    // Asynchronous reset: outputs clear before the next rising edge.
    #2;
    rst = 1'b1;
    #1;
    chk("async_hcount",      32'(hcount_out),  32'd0);
    chk("async_vcount",      32'(vcount_out),  32'd0);
    chk("async_hsync",       32'(hsync_out),   32'd0);
    chk("async_vsync",       32'(vsync_out),   32'd0);
    chk("async_hblnk",       32'(hblnk_out),   32'd0);
    chk("async_vblnk",       32'(vblnk_out),   32'd0);
    chk("async_frame_start", 32'(frame_start), 32'd0);
    chk("async_frame_cnt",   32'(frame_cnt),   32'd0);

    for (int i = 0; i < 2; i++) tick();

    rst = 1'b0;
    #1;
    model_reset();
    push_expected(1'b0);
    pop_compare();

    // One full frame after the restart: origin reached exactly on time.
    fs_count = 0;
    fs_last  = 0;
    for (int i = 1; i <= FRAME; i++) begin
      tick();
      if (frame_start) begin
        fs_count++;
        fs_last = i;
      end
    end
    chk("restart_pulses", 32'(fs_count), 32'd1);
    chk("restart_pulse_at", 32'(fs_last), 32'(FRAME));

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
